pwm_multi_ch: RTL and testbench

//   Multi-channel PWM generator: one shared period counter drives CH independent compare channels.
//   Per-channel duty values are double-buffered and committed only at the period boundary, so outputs never glitch.

---
 rtl/pwm_pkg.sv | 17 +
 rtl/pwm_channel.sv | 42 ++++
 rtl/pwm_multi_ch.sv | 86 ++++++++
 tb/tb_pwm_multi_ch.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared definitions for the multi-channel PWM generator: default sizing,
// the duty value type and the duty clamp helper.
package pwm_pkg;

  localparam int PWM_DEF_PERIOD = 100;
  localparam int PWM_DEF_CH     = 4;
  localparam int PWM_DEF_DUTY_W = 7;
  localparam int PWM_DEF_CH_W   = 2;

  typedef logic [PWM_DEF_DUTY_W-1:0] duty_t;

  // Limit a requested duty to the period length; anything larger means "always on".
  function automatic logic [15:0] duty_clamp(input logic [15:0] d, input logic [15:0] period);
    return (d > period) ? period : d;
  endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM compare channel: a shadow register takes writes at any time, the
// active register only changes on the commit strobe, and the output bit is
// registered from the active duty and the channel phase.
module pwm_channel
  import pwm_pkg::*;
#(
  parameter int DUTY_W = PWM_DEF_DUTY_W
) (
  input  logic              clk,
  input  logic              sys_rst,
  input  logic              en,
  input  logic              commit,
  input  logic              wr_en,
  input  logic [DUTY_W-1:0] wr_data,
  input  logic [DUTY_W-1:0] phase,
  output logic              pwm_out
);

  logic [DUTY_W-1:0] shadow;
  logic [DUTY_W-1:0] active;
  logic [DUTY_W-1:0] shadow_next;

  // A write landing in the commit cycle goes straight into the active duty.
  always_comb begin
    shadow_next = shadow;
    if (wr_en) shadow_next = wr_data;
  end

  // Shadow/active duty registers and the registered compare output.
  always_ff @(posedge clk) begin
    if (sys_rst) begin
      shadow  <= '0;
      active  <= '0;
      pwm_out <= 1'b0;
    end else begin
      shadow <= shadow_next;
      if (commit) active <= shadow_next;
      pwm_out <= en & (phase < active);
    end
  end

endmodule

// File: rtl/pwm_multi_ch.sv
// Multi-channel PWM generator. One shared period counter feeds CH compare
// channels; duty values are double-buffered and committed at the period
// boundary so outputs never glitch.
// Build option: define PWM_PHASE_STAGGER_EN to spread channel phases evenly
// across the period, with each channel committing at its own boundary.
module pwm_multi_ch
  import pwm_pkg::*;
#(
  parameter int CH     = PWM_DEF_CH,
  parameter int PERIOD = PWM_DEF_PERIOD,
  parameter int DUTY_W = PWM_DEF_DUTY_W,
  parameter int CH_W   = PWM_DEF_CH_W
) (
  input  logic              clk,
  input  logic              sys_rst,
  input  logic              en,
  input  logic              duty_wr_en,
  input  logic [CH_W-1:0]   duty_wr_ch,
  input  logic [DUTY_W-1:0] duty_wr_data,
  output logic [CH-1:0]     pwm_out,
  output logic              period_start
);

  localparam logic [DUTY_W-1:0] CNT_LAST = DUTY_W'(PERIOD - 1);

  logic [DUTY_W-1:0] cnt;
  logic [DUTY_W-1:0] wr_data_c;

  assign wr_data_c = DUTY_W'(duty_clamp(16'(duty_wr_data), 16'(PERIOD)));

  // Shared period counter: parked at 0 while disabled, wraps at PERIOD-1.
  always_ff @(posedge clk) begin
    if (sys_rst) begin
      cnt <= '0;
    end else if (!en) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Period marker, registered so it lines up with the first output cycle of the period.
  always_ff @(posedge clk) begin
    if (sys_rst) period_start <= 1'b0;
    else         period_start <= en & (cnt == '0);
  end

  for (genvar i = 0; i < CH; i++) begin : g_ch
    logic              wr_hit;
    logic              commit;
    logic [DUTY_W-1:0] phase;

    // Out-of-range channel indices never match any channel and are dropped.
    assign wr_hit = duty_wr_en && (duty_wr_ch == CH_W'(i));

`ifdef PWM_PHASE_STAGGER_EN
    localparam int PH_OFF = i * (PERIOD / CH);
    logic [DUTY_W:0] phase_sum;
    assign phase_sum = {1'b0, cnt} + (DUTY_W+1)'(PERIOD - PH_OFF);
    assign phase = (phase_sum >= (DUTY_W+1)'(PERIOD))
                 ? DUTY_W'(phase_sum - (DUTY_W+1)'(PERIOD))
                 : phase_sum[DUTY_W-1:0];
`else
    assign phase = cnt;
`endif

    // Disabled channels track their shadow continuously so re-enable starts fresh.
    assign commit = !en || (phase == CNT_LAST);

    pwm_channel #(
      .DUTY_W (DUTY_W)
    ) u_channel (
      .clk     (clk),
      .sys_rst (sys_rst),
      .en      (en),
      .commit  (commit),
      .wr_en   (wr_hit),
      .wr_data (wr_data_c),
      .phase   (phase),
      .pwm_out (pwm_out[i])
    );
  end

endmodule

// File: tb/tb_pwm_multi_ch.sv
// Bench for pwm_multi_ch (CH=4, PERIOD=100, DUTY_W=7) plus a CH=3 instance
// that shares all inputs for the out-of-range channel index case.
module tb_pwm_multi_ch;

  logic       clk;
  logic       sys_rst;
  logic       en;
  logic       duty_wr_en;
  logic [1:0] duty_wr_ch;
  logic [6:0] duty_wr_data;
  logic [3:0] pwm_out;
  logic       period_start;
  logic [2:0] pwm_out3;
  logic       period_start3;

  int n_vec;
  int n_err;
  int hi_cnt[4];
  int hi3_cnt[3];
  int ps_cnt;
  int ps_first;
  int samp;

  typedef struct packed {
    logic [3:0][6:0] d;
    logic [3:0][6:0] e;
  } vec_t;

  vec_t vecs[3];

  pwm_multi_ch #(.CH(4), .PERIOD(100), .DUTY_W(7), .CH_W(2)) dut (
    .clk          (clk),
    .sys_rst      (sys_rst),
    .en           (en),
    .duty_wr_en   (duty_wr_en),
    .duty_wr_ch   (duty_wr_ch),
    .duty_wr_data (duty_wr_data),
    .pwm_out      (pwm_out),
    .period_start (period_start)
  );

  pwm_multi_ch #(.CH(3), .PERIOD(100), .DUTY_W(7), .CH_W(2)) dut3 (
    .clk          (clk),
    .sys_rst      (sys_rst),
    .en           (en),
    .duty_wr_en   (duty_wr_en),
    .duty_wr_ch   (duty_wr_ch),
    .duty_wr_data (duty_wr_data),
    .pwm_out      (pwm_out3),
    .period_start (period_start3)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_counts();
    for (int i = 0; i < 4; i++) hi_cnt[i] = 0;
    for (int i = 0; i < 3; i++) hi3_cnt[i] = 0;
    ps_cnt   = 0;
    ps_first = -1;
    samp     = 0;
  endtask

  // Advance n clocks, sampling outputs 1 time unit after each rising edge.
  task automatic run(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) if (pwm_out[i]) hi_cnt[i]++;
      for (int i = 0; i < 3; i++) if (pwm_out3[i]) hi3_cnt[i]++;
      if (period_start) begin
        if (ps_first < 0) ps_first = samp;
        ps_cnt++;
      end
      samp++;
    end
  endtask

  task automatic write_duty(input int ch, input int data);
    duty_wr_en   = 1'b1;
    duty_wr_ch   = 2'(ch);
    duty_wr_data = 7'(data);
    run(1);
    duty_wr_en   = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    sys_rst = 1'b1;
    en = 1'b0;
    duty_wr_en = 1'b0;
    duty_wr_ch = '0;
    duty_wr_data = '0;

    vecs[0].d = {7'd120, 7'd100, 7'd0,   7'd50};
    vecs[0].e = {7'd100, 7'd100, 7'd0,   7'd50};
    vecs[1].d = {7'd30,  7'd127, 7'd99,  7'd1};
    vecs[1].e = {7'd30,  7'd100, 7'd99,  7'd1};
    vecs[2].d = {7'd101, 7'd2,   7'd25,  7'd70};
    vecs[2].e = {7'd100, 7'd2,   7'd25,  7'd70};

    // Reset state
    clear_counts();
    run(5);
    check("reset_pwm_out", int'(pwm_out), 0);
    check("reset_period_start", int'(period_start), 0);

    // ch0=50 written as counting starts: first period low, then 50 high per period
    sys_rst = 1'b0;
    en = 1'b1;
    duty_wr_en = 1'b1; duty_wr_ch = 2'd0; duty_wr_data = 7'd50;
    clear_counts();
    run(1);
    duty_wr_en = 1'b0;
    check("t1_first_ps_pos", ps_first, 0);
    run(99);
    check("t1_first_period_hi", hi_cnt[0], 0);
    check("t1_first_period_ps", ps_cnt, 1);
    clear_counts();
    run(100);
    check("t1_second_period_hi", hi_cnt[0], 50);
    check("t1_second_period_ps", ps_cnt, 1);
    check("t1_second_ps_pos", ps_first, 0);

    // Write 70 at period start: current period keeps 50
    clear_counts();
    write_duty(0, 70);
    run(99);
    check("t3_unchanged_period", hi_cnt[0], 50);
    // Period at 70, write 30 at cnt=40: this period 70, next 30
    clear_counts();
    run(40);
    duty_wr_en = 1'b1; duty_wr_ch = 2'd0; duty_wr_data = 7'd30;
    run(1);
    duty_wr_en = 1'b0;
    run(59);
    check("t3_mid_write_period", hi_cnt[0], 70);
    clear_counts();
    run(100);
    check("t3_next_period", hi_cnt[0], 30);
    check("t3_next_period_ps", ps_cnt, 1);

    // Table: duties loaded while disabled, one full enabled period observed
    for (int v = 0; v < 3; v++) begin
      en = 1'b0;
      run(1);
      for (int c = 0; c < 4; c++) write_duty(c, int'(vecs[v].d[c]));
      en = 1'b1;
      clear_counts();
      run(100);
      for (int c = 0; c < 4; c++)
        check($sformatf("vec%0d_ch%0d_hi", v, c), hi_cnt[c], int'(vecs[v].e[c]));
      check($sformatf("vec%0d_ps_pos", v), ps_first, 0);
      check($sformatf("vec%0d_ps_cnt", v), ps_cnt, 1);
    end

    // Out-of-range index on the CH=3 instance is ignored
    en = 1'b0;
    run(1);
    write_duty(0, 0);
    write_duty(1, 0);
    write_duty(2, 0);
    write_duty(3, 10);
    en = 1'b1;
    clear_counts();
    run(100);
    for (int c = 0; c < 3; c++) check($sformatf("t4_ch3dut_ch%0d_hi", c), hi3_cnt[c], 0);
    check("t4_ch4dut_ch3_hi", hi_cnt[3], 10);
    en = 1'b0;
    run(1);
    write_duty(1, 40);
    en = 1'b1;
    clear_counts();
    run(100);
    check("t4_ch3dut_ch0_hi", hi3_cnt[0], 0);
    check("t4_ch3dut_ch1_hi", hi3_cnt[1], 40);
    check("t4_ch3dut_ch2_hi", hi3_cnt[2], 0);

    // Reset at cnt=60 while running
    en = 1'b0;
    run(1);
    write_duty(0, 80);
    write_duty(1, 0);
    write_duty(2, 100);
    write_duty(3, 0);
    en = 1'b1;
    clear_counts();
    run(60);
    check("t5_pre_reset_pwm", int'(pwm_out), 5);
    check("t5_pre_reset_ch0_hi", hi_cnt[0], 60);
    sys_rst = 1'b1;
    run(1);
    check("t5_reset_pwm", int'(pwm_out), 0);
    check("t5_reset_ps", int'(period_start), 0);
    sys_rst = 1'b0;
    clear_counts();
    run(100);
    check("t5_after_ch0_hi", hi_cnt[0], 0);
    check("t5_after_ch2_hi", hi_cnt[2], 0);
    check("t5_after_ps_pos", ps_first, 0);

    // Disable mid-period, then re-enable with a fresh duty
    clear_counts();
    write_duty(0, 90);
    run(99);
    check("t6_uncommitted_hi", hi_cnt[0], 0);
    clear_counts();
    run(50);
    check("t6_running_hi", hi_cnt[0], 50);
    en = 1'b0;
    clear_counts();
    run(30);
    check("t6_disabled_hi", hi_cnt[0], 0);
    check("t6_disabled_ps", ps_cnt, 0);
    write_duty(0, 20);
    en = 1'b1;
    clear_counts();
    run(100);
    check("t6_reenable_hi", hi_cnt[0], 20);
    check("t6_reenable_ps_pos", ps_first, 0);
    check("t6_reenable_ps_cnt", ps_cnt, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
